// File: rtl/uart_tx_core_pkg.sv
// Shared UART TX definitions: FSM state encodings and line levels.
// UART_TX_PARITY_EN adds the PARITY state encoding.
package uart_tx_core_pkg;

  localparam int unsigned STATE_BITS = 3;

  localparam logic [STATE_BITS-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_BITS-1:0] ST_START  = 3'd1;
  localparam logic [STATE_BITS-1:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [STATE_BITS-1:0] ST_PARITY = 3'd3;
`endif
  localparam logic [STATE_BITS-1:0] ST_STOP   = 3'd4;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_core_if.sv
// Host write port and status/serial outputs of the UART transmit core.
interface uart_tx_core_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PTR_BITS  = 3
);
  logic                 wr_Sig;
  logic [DATA_BITS-1:0] wr_Data;
  logic                 tx;
  logic                 tx_Busy;
  logic                 sig_Full;
  logic                 sig_Empty;
  logic [PTR_BITS:0]    fifo_Count;
  logic                 sig_Overflow;

  modport master (
    output wr_Sig, wr_Data,
    input  tx, tx_Busy, sig_Full, sig_Empty, fifo_Count, sig_Overflow
  );

  modport slave (
    input  wr_Sig, wr_Data,
    output tx, tx_Busy, sig_Full, sig_Empty, fifo_Count, sig_Overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// TX word FIFO: storage, wrapping pointers, occupancy, full/empty and sticky overflow.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PTR_BITS   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_data_c,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_BITS:0]    count,
  output logic                 overflow
);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic [PTR_BITS:0]    count_d;
  logic                 accept;
  logic                 pop_ok;

  // A write while full is dropped even if a pop frees a slot on the same edge
  assign accept = wr && !full;
  assign pop_ok = pop && !empty;

  always_comb begin
    count_d = count;
    case ({accept, pop_ok})
      2'b10:   count_d = count + (PTR_BITS+1)'(1);
      2'b01:   count_d = count - (PTR_BITS+1)'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count_d;
      full  <= (count_d == (PTR_BITS+1)'(FIFO_DEPTH));
      empty <= (count_d == '0);
      if (wr && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: baud divider, frame FSM and serializer fed by uart_tx_fifo.
// Optional parity stage enabled by defining UART_TX_PARITY_EN.
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PTR_BITS   = 3,
  parameter int unsigned CLK_DIV    = 2604,
  parameter int unsigned DIV_BITS   = 12,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic           clk,
  input logic           reset,
  uart_tx_core_if.slave bus
);

  localparam int unsigned IDX_BITS = 4;

  logic [STATE_BITS-1:0] state_q, state_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_tick;
  logic                  load;
  logic [DATA_BITS-1:0]  fifo_head;
  logic                  fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_BITS  (PTR_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (bus.wr_Sig),
    .wr_data  (bus.wr_Data),
    .pop      (load),
    .rd_data_c(fifo_head),
    .full     (bus.sig_Full),
    .empty    (fifo_empty),
    .count    (bus.fifo_Count),
    .overflow (bus.sig_Overflow)
  );

  assign bit_tick = (div_q == DIV_BITS'(CLK_DIV - 1));

  // Next-state, divider and serializer update; tx is computed from the next state
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    load    = 1'b0;
    tx_d    = IDLE_LEVEL;
    busy_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != ST_IDLE) div_d = bit_tick ? '0 : div_q + DIV_BITS'(1);

    case (state_q)
      ST_IDLE:  if (!fifo_empty) load = 1'b1;
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_BITS'(1);
          if (idx_q == IDX_BITS'(DATA_BITS - 1)) begin
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when more data is queued
            if (!fifo_empty) load = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d = fifo_head;
      idx_d   = '0;
      div_d   = '0;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      par_d   = (^fifo_head) ^ 1'(PARITY_ODD);
`endif
    end

    case (state_d)
      ST_START:  tx_d = START_LEVEL;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifndef UART_TX_PARITY_EN
  // Parity sense has no effect without the parity stage
  if (PARITY_ODD > 1) begin : g_parity_odd_unused
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.tx        = tx_q;
  assign bus.tx_Busy   = busy_q;
  assign bus.sig_Empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frame-level reference model compared every cycle,
// plus directed literal checks. CLK_DIV=4, DATA_BITS=8, FIFO_DEPTH=8, STOP_BITS=2.
module tb_uart_tx_core;

  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PB    = 3;
  localparam int unsigned CD    = 4;
  localparam int unsigned SB    = 2;
  localparam logic        PODD  = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P         = 1;
  localparam int unsigned FRAME_LIT = 48;
`else
  localparam int unsigned P         = 0;
  localparam int unsigned FRAME_LIT = 44;
`endif
  localparam int FRAME = int'((1 + DB + P + SB) * CD);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_core_if #(.DATA_BITS(DB), .PTR_BITS(PB)) bus ();

  uart_tx_core #(
    .DATA_BITS (DB),
    .FIFO_DEPTH(DEPTH),
    .PTR_BITS  (PB),
    .CLK_DIV   (CD),
    .DIV_BITS  (12),
    .STOP_BITS (SB),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  // Reference model: FIFO as a queue, current frame as (word, cycle offset)
  logic [DB-1:0] mq[$];
  bit            m_busy = 1'b0;
  int            m_off  = 0;
  logic [DB-1:0] m_word = '0;
  bit            m_ovf  = 1'b0;
  bit            m_wr;
  logic [DB-1:0] m_wd;
  bit            m_full_pre;
  bit            m_can_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_busy = 1'b0;
      m_off  = 0;
      m_ovf  = 1'b0;
    end else begin
      m_wr       = bus.wr_Sig;
      m_wd       = bus.wr_Data;
      m_full_pre = (mq.size() == int'(DEPTH));
      m_can_pop  = (mq.size() != 0);
      if (!m_busy || m_off == FRAME - 1) begin
        if (m_can_pop) begin
          m_word = mq.pop_front();
          m_busy = 1'b1;
          m_off  = 0;
        end else begin
          m_busy = 1'b0;
          m_off  = 0;
        end
      end else begin
        m_off++;
      end
      if (m_wr) begin
        if (m_full_pre) m_ovf = 1'b1;
        else            mq.push_back(m_wd);
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_off / int'(CD);
    if (b == 0) return 1'b0;
    if (b <= int'(DB)) return m_word[b-1];
    if (P == 1 && b == int'(DB) + 1) return (^m_word) ^ PODD;
    return 1'b1;
  endfunction

  function automatic logic [8:0] exp_vec();
    return {exp_tx(), m_busy, (mq.size() == int'(DEPTH)), (mq.size() == 0), 4'(mq.size()), m_ovf};
  endfunction

  logic [8:0] dut_vec;
  assign dut_vec = {bus.tx, bus.tx_Busy, bus.sig_Full, bus.sig_Empty, bus.fifo_Count, bus.sig_Overflow};

  always @(negedge clk) begin
    if (chk_en) check("cycle_vs_model", 32'(dut_vec), 32'(exp_vec()));
  end

  logic cap_tx   [64];
  logic cap_busy [64];

  // Write one word while idle and record tx/busy for the whole frame (index 0 = write edge)
  task automatic capture_frame(input logic [DB-1:0] w);
    bus.wr_Sig  = 1'b1;
    bus.wr_Data = w;
    @(posedge clk); #1;
    bus.wr_Sig = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      cap_tx[i]   = bus.tx;
      cap_busy[i] = bus.tx_Busy;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [DB-1:0] cap_byte();
    logic [DB-1:0] r;
    for (int b = 0; b < int'(DB); b++) r[b] = cap_tx[1 + int'(CD) * (b + 1) + int'(CD) / 2];
    return r;
  endfunction

  function automatic int busy_sum();
    int s = 0;
    for (int i = 0; i < FRAME + 2; i++) s += int'(cap_busy[i]);
    return s;
  endfunction

  initial begin
    bit found;
    reset       = 1'b1;
    bus.wr_Sig  = 1'b0;
    bus.wr_Data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_vec), 32'(9'b1_0_0_1_0000_0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 0xA5: start one cycle after the write, LSB first, busy for one frame
    capture_frame(8'hA5);
    check("a5_start_edge", 32'({cap_tx[0], cap_tx[1]}), 32'(2'b10));
    check("a5_data_bits", 32'(cap_byte()), 32'(8'hA5));
    check("a5_stop_level", 32'({cap_tx[43], cap_tx[FRAME]}), 32'(2'b11));
    check("a5_busy_cycles", 32'(busy_sum()), 32'(FRAME_LIT));
    check("a5_busy_drop", 32'({cap_busy[FRAME], cap_busy[FRAME + 1]}), 32'(2'b10));

    // 0x07: slot after data is even parity (1) when compiled in, else the first stop bit (1)
    capture_frame(8'h07);
    check("x07_data_bits", 32'(cap_byte()), 32'(8'h07));
    check("x07_parity_slot", 32'(cap_tx[39]), 32'(1'b1));

    // Ten back-to-back writes from idle: first pops, eight fill, tenth overflows
    for (int i = 0; i < 10; i++) begin
      bus.wr_Sig  = 1'b1;
      bus.wr_Data = 8'h10 + 8'(i);
      @(posedge clk); #1;
      if (i == 8) check("fill_full", 32'({bus.fifo_Count, bus.sig_Full, bus.sig_Overflow}), 32'(6'b1000_1_0));
    end
    bus.wr_Sig = 1'b0;
    check("fill_overflow", 32'({bus.fifo_Count, bus.sig_Full, bus.sig_Overflow}), 32'(6'b1000_1_1));

    // Write on the same edge as a back-to-back pop with three words queued
    found = 1'b0;
    for (int k = 0; k < 10 * FRAME; k++) begin
      if (mq.size() == 3 && m_busy && m_off == FRAME - 1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) timeout_fail("wait_count3");
    bus.wr_Sig  = 1'b1;
    bus.wr_Data = 8'hC3;
    @(posedge clk); #1;
    bus.wr_Sig = 1'b0;
    check("wrpop_count", 32'(bus.fifo_Count), 32'(3));
    check("b2b_start", 32'({bus.tx, bus.tx_Busy}), 32'(2'b01));

    found = 1'b0;
    for (int k = 0; k < 6 * FRAME; k++) begin
      @(posedge clk); #1;
      if (!m_busy && mq.size() == 0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout_fail("wait_drain");
    check("drained", 32'({bus.sig_Empty, bus.tx_Busy, bus.tx}), 32'(3'b101));
    check("overflow_sticky", 32'(bus.sig_Overflow), 32'(1'b1));

    // Reset in the middle of data bits discards the frame and the queue
    for (int i = 0; i < 3; i++) begin
      bus.wr_Sig  = 1'b1;
      bus.wr_Data = (i == 0) ? 8'h5A : (i == 1) ? 8'h66 : 8'h99;
      @(posedge clk); #1;
    end
    bus.wr_Sig = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_count", 32'({bus.fifo_Count, bus.tx_Busy}), 32'(5'b0010_1));
    reset = 1'b1;
    #1;
    check("mid_reset", 32'({bus.tx, bus.tx_Busy, bus.fifo_Count, bus.sig_Empty, bus.sig_Overflow}),
          32'(8'b1_0_0000_1_0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    capture_frame(8'h3C);
    check("post_reset_data", 32'(cap_byte()), 32'(8'h3C));
    check("post_reset_start", 32'({cap_tx[0], cap_tx[1]}), 32'(2'b10));

    repeat (4) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
